// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants, default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS           = 11;
  localparam bit          PARITY_EVEN          = 1'b1;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  // Parity bit the transmitter appends for a given data byte
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return PARITY_EVEN ? (^d) : ~(^d);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchroniser and falling-edge detector.
// With UART_RX_MAJORITY_EN defined, rx_s_c is the 2-of-3 majority of the
// synchronised line around a centre tap delayed by one cycle, so every
// sample point (and the edge flag) moves one cycle later.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s_c,
  output logic fall_c
);

  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;
`ifdef UART_RX_MAJORITY_EN
  logic rx_dly_q, rx_dly_d;
`endif

  // Next values of the synchroniser / history chain
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
`ifdef UART_RX_MAJORITY_EN
    rx_dly_d  = rx_sync_q;
    rx_prev_d = rx_dly_q;
`else
    rx_prev_d = rx_sync_q;
`endif
  end

  // Chain registers; line idles high so reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_dly_q  <= 1'b1;
`endif
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
`ifdef UART_RX_MAJORITY_EN
      rx_dly_q  <= rx_dly_d;
`endif
    end
  end

  // Bit value and start-edge flag seen by the receiver FSM
  always_comb begin
`ifdef UART_RX_MAJORITY_EN
    rx_s_c = (rx_sync_q & rx_dly_q) | (rx_sync_q & rx_prev_q) | (rx_dly_q & rx_prev_q);
    fall_c = !rx_dly_q && rx_prev_q;
`else
    rx_s_c = rx_sync_q;
    fall_c = !rx_sync_q && rx_prev_q;
`endif
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Byte is held on a valid/ready register with parity, framing and overrun flags.
// Optional 3-tap majority sampling: define UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s_c;
  logic fall_c;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 valid_q, valid_d;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_s_c (rx_s_c),
    .fall_c (fall_c)
  );

  // Next-state, datapath and holding-register logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    valid_d = valid_q;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_c ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_c, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == DATA_LAST) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_c;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          // Load unless an un-accepted byte is still held
          if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            perr_d  = (parity_bit(shift_q) != par_q);
            ferr_d  = !rx_s_c;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
    end
  end

  assign rx_valid    = valid_q;
  assign data_out    = data_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] data_out;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  int checks   = 0;
  int failures = 0;

  rec_t exp_q[$];
  rec_t obs_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .rx_valid    (rx_valid),
    .data_out    (data_out),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // Record every accepted byte
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) obs_q.push_back({data_out, parity_err, frame_err});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic par, input logic stop);
    rec_t r;
    r.data = d;
    r.perr = (par != (^d));
    r.ferr = !stop;
    exp_q.push_back(r);
  endtask

  task automatic wait_obs(input int n, output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obs_q.size() >= n) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    idle(3);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (data_out !== 8'h00)   begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if (parity_err !== 1'b0)  begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0)   begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun_err); end
    idle(1);
    rst = 1'b0;
    idle(4);
  endtask

  // Single frame with ready high; compares one scoreboard entry
  task automatic test_frame(input string name, input logic [7:0] d, input logic par, input logic stop);
    rec_t e, o;
    bit got;
    rx_ready = 1'b1;
    push_exp(d, par, stop);
    send_frame(d, par, stop);
    wait_obs(1, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s_timeout got=no byte exp=%h", name, d);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, o.data, e.data); end
      checks++; if (o.perr !== e.perr) begin failures++; $display("FAIL %s_perr got=%b exp=%b", name, o.perr, e.perr); end
      checks++; if (o.ferr !== e.ferr) begin failures++; $display("FAIL %s_ferr got=%b exp=%b", name, o.ferr, e.ferr); end
    end
  endtask

  task automatic test_basic();
    test_frame("basic", 8'hA5, 1'b0, 1'b1);
    idle(20);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL basic_pulses got=%0d extra exp=0", obs_q.size()); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_low got=%b exp=0", rx_valid); end
  endtask

  task automatic test_parity();
    test_frame("parity", 8'h01, 1'b0, 1'b1);
    idle(CPB);
  endtask

  task automatic test_framing();
    test_frame("framing", 8'h3C, 1'b0, 1'b0);
    idle(40);
    rx = 1'b1;
    idle(3 * CPB);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL framing_extra got=%0d bytes exp=0", obs_q.size()); end
  endtask

  task automatic test_overrun();
    rec_t e, o;
    rx_ready = 1'b0;
    push_exp(8'h11, ^8'h11, 1'b1);
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    idle(5);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1)    begin failures++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    checks++; if (data_out !== 8'h11)   begin failures++; $display("FAIL ovr_data got=%h exp=11", data_out); end
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL ovr_valid_clr got=%b exp=0", rx_valid); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_flag_clr got=%b exp=0", overrun_err); end
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL ovr_transfers got=%0d exp=1", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL ovr_xfer_data got=%h exp=%h", o.data, e.data); end
    end
    rx_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (obs_q.size() != 0)    begin failures++; $display("FAIL glitch_bytes got=%0d exp=0", obs_q.size()); end
    checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    rx_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    idle(CPB / 2);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (data_out !== 8'h00)   begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
    checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3 * CPB);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_partial got=%0d bytes exp=0", obs_q.size()); end
    test_frame("after_rst", 8'h5A, ^8'h5A, 1'b1);
    idle(CPB);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    rec_t e, o;
    bit got;
    d[0] = 8'hC3; d[1] = 8'h7E; d[2] = 8'($urandom_range(0, 255));
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(d[i], ^d[i], 1'b1);
      send_frame(d[i], ^d[i], 1'b1);
    end
    wait_obs(3, got);
    checks++;
    if (!got) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if (o !== e) begin failures++; $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/%b/%b", i, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream peer of the team's transmitter.
- Deserialises one 11-bit frame: start (0), 8 data bits LSB first, even-parity bit (XOR of the data bits), stop (1).
- Presents the byte on a valid/ready holding register and flags parity, framing and overrun errors.
- Sits between the board RX pin and the byte consumer (loopback checker or command FIFO).

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200). Minimum 8.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the start-bit sample.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line, idle high
- rx_ready  in  1  consumer accepts the byte when high together with rx_valid
- rx_valid  out  1  byte held in data_out is valid
- data_out  out  8  received byte
- parity_err  out  1  parity mismatch for the held byte
- frame_err  out  1  stop bit sampled 0 for the held byte
- overrun_err  out  1  a frame was dropped while rx_valid was pending

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.

Input synchroniser:
- rx passes through a 2-flop synchroniser (reset value 1'b1) giving rx_s.
- A start edge is rx_s == 0 while its previous registered value is 1.

Reset values:
- rx_valid = 0, data_out = 8'h00, all error flags = 0.
- FSM = IDLE, bit counter = 0, cycle counter = 0.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is delivered.

FSM states and transitions:
- IDLE: on a start edge, clear the cycle counter and go to START.
- START: at cycle count HALF_BIT-1, sample rx_s.
  - rx_s == 0: clear counters, go to DATA.
  - rx_s == 1: false start (glitch), go to IDLE.
- DATA: sample every CLKS_PER_BIT cycles.
  - Each sample shifts into the shift register at bit 7, shifting right, so the LSB arrives first.
  - After the 8th sample, go to PARITY.
- PARITY: after CLKS_PER_BIT cycles, sample the parity bit; go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample the stop bit.
  - Perform frame completion (below), then go to IDLE in the same cycle.
  - Re-arming happens at mid-stop-bit. A new start edge needs rx_s to return high first, so a line held low after a framing error generates no further frames.

Frame completion (one cycle):
- If rx_valid == 0, or (rx_valid && rx_ready) in this same cycle:
  - Load data_out with the byte.
  - parity_err = (^byte) != parity sample.
  - frame_err = !stop sample.
  - Set rx_valid = 1.
- Else (rx_valid && !rx_ready): discard the new frame. data_out and its flags stay unchanged; set overrun_err = 1.

Handshake:
- A transfer occurs on any cycle with rx_valid && rx_ready.
- rx_valid deasserts the next cycle unless a completion loads a new byte in the same cycle; in that case rx_valid stays 1 with the new data.
- overrun_err clears on a transfer.
- data_out and all flags are stable while rx_valid = 1 and no transfer occurs.

Latency:
- rx_valid rises 1 cycle after the stop-bit sample cycle.
- The stop-bit sample occurs 2 + HALF_BIT + 10*CLKS_PER_BIT cycles after rx falls (±1 for edge alignment).

Counter widths:
- Cycle counter width = $clog2(CLKS_PER_BIT). Bit counter is 3 bits and wraps at 7 → exit.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of rx_s at sample point −1, 0 and +1 cycles.
  - Adds one cycle to the rx_valid latency.
  - A single-cycle glitch at the sample point does not corrupt the bit.
- Undefined: a single sample of rx_s at the sample point.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Frame constants: DATA_BITS=8, FRAME_BITS=11, PARITY_EVEN=1.
  - Default CLKS_PER_BIT, shared with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchroniser plus the optional 3-tap majority sampler. It outputs rx_s and a falling-edge flag.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8):
- Send 8'hA5, parity 0, stop 1, rx_ready=1 → one rx_valid pulse; data_out=8'hA5; parity_err=0, frame_err=0.
- Send 8'h01 with parity 0 (wrong) → data_out=8'h01, parity_err=1, frame_err=0.
- Send 8'h3C with stop bit 0 → frame_err=1. Hold rx low for 40 cycles → no second rx_valid.
- rx_ready=0; send 8'h11 then 8'h22 → data_out stays 8'h11, overrun_err=1. Raise rx_ready for one cycle → rx_valid=0, overrun_err=0.
- Drive a 4-cycle low glitch on idle rx → FSM returns to IDLE; no rx_valid.
- Assert rst at the 5th data bit of 8'hFF → all outputs at reset values. A following frame 8'h5A is received correctly.
